// File: rtl/operand_fetch_pkg.sv
// Shared widths, opcode type and bank-slicing helper for the operand fetch stage.
// Latency: none (declarations only).
// Backpressure: not applicable.
package operand_fetch_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 16;
    localparam int SEL_W  = $clog2(REG_N);
    localparam int IMM_W  = 8;
    localparam int SEXT_W = DATA_W - IMM_W;

    typedef logic [3:0] opcode_t;

    // Pull register k out of the flattened bank bus.
    function automatic logic [DATA_W-1:0] reg_slice(
        input logic [REG_N*DATA_W-1:0] bank,
        input logic [SEL_W-1:0]        k
    );
        return bank[int'(k)*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction-in and operand-out channels of the operand fetch stage.
// Latency: none (wiring only).
// Backpressure: InReady upstream, OutReady from execute.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    // Instruction channel
    logic              InValid;
    logic              InReady;
    logic [SEL_W-1:0]  SrcA;
    logic [SEL_W-1:0]  SrcB;
    logic              UseSrcA;
    logic              UseSrcB;
    logic              UseImm;
    logic [IMM_W-1:0]  Imm;
    logic [SEL_W-1:0]  Dest;
    logic              WriteDest;
    opcode_t           Opcode;

    // Operand channel
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OperandA;
    logic [DATA_W-1:0] OperandB;
    logic [SEL_W-1:0]  OutDest;
    logic              OutWriteDest;
    opcode_t           OutOpcode;

    // Stage view
    modport slave (
        input  InValid, SrcA, SrcB, UseSrcA, UseSrcB, UseImm, Imm, Dest,
               WriteDest, Opcode, OutReady,
        output InReady, OutValid, OperandA, OperandB, OutDest, OutWriteDest,
               OutOpcode
    );

    // Decode / execute view
    modport master (
        output InValid, SrcA, SrcB, UseSrcA, UseSrcB, UseImm, Imm, Dest,
               WriteDest, Opcode, OutReady,
        input  InReady, OutValid, OperandA, OperandB, OutDest, OutWriteDest,
               OutOpcode
    );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back.
// Latency: lookups are combinational; set/clear take effect after the edge.
// Backpressure: none; the caller decides when to set.
module operand_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [SEL_W-1:0] set_sel,
    input  logic             clr_en,
    input  logic [SEL_W-1:0] clr_sel,
    input  logic [SEL_W-1:0] sel_a,
    input  logic [SEL_W-1:0] sel_b,
    input  logic [SEL_W-1:0] sel_d,
    output logic             pend_a,
    output logic             pend_b,
    output logic             pend_d
);

    logic [REG_N-1:0] pending;
    logic [REG_N-1:0] set_mask;
    logic [REG_N-1:0] clr_mask;

    // Decode set/clear selects into one-hot masks.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_sel] = 1'b1;
        if (clr_en) clr_mask[clr_sel] = 1'b1;
    end

    // Lookups see a same-cycle write-back as already cleared.
    always_comb begin
        pend_a = pending[sel_a] && !(clr_en && (clr_sel == sel_a));
        pend_b = pending[sel_b] && !(clr_en && (clr_sel == sel_b));
        pend_d = pending[sel_d] && !(clr_en && (clr_sel == sel_d));
    end

    // Clear first, then set, so a same-register set wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: selects/forwards source operands, stalls on RAW/WAW hazards, one output slot.
// Latency: accept at edge N presents the result after edge N.
// Backpressure: InReady drops on hazards or when the full slot is not being drained.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                    Clock,
    input  logic                    reset,
    input  logic [REG_N*DATA_W-1:0] RegFile,
    input  logic                    WbEnable,
    input  logic [SEL_W-1:0]        WbSelect,
    input  logic [DATA_W-1:0]       WbData,
    operand_fetch_if.slave          bus
);

    logic              pend_a;
    logic              pend_b;
    logic              pend_d;
    logic              hazard;
    logic              waw;
    logic              in_ready;
    logic              accept;
    logic              use_b_reg;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    logic              out_valid;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [SEL_W-1:0]  out_dest;
    logic              out_wd;
    opcode_t           out_op;

    operand_scoreboard u_scoreboard (
        .clk     (Clock),
        .reset   (reset),
        .set_en  (accept && bus.WriteDest),
        .set_sel (bus.Dest),
        .clr_en  (WbEnable),
        .clr_sel (WbSelect),
        .sel_a   (bus.SrcA),
        .sel_b   (bus.SrcB),
        .sel_d   (bus.Dest),
        .pend_a  (pend_a),
        .pend_b  (pend_b),
        .pend_d  (pend_d)
    );

    // Hazard detection and handshake; InReady ignores InValid on purpose.
    always_comb begin
        use_b_reg = bus.UseSrcB && !bus.UseImm;
        hazard    = (bus.UseSrcA && pend_a) || (use_b_reg && pend_b);
        waw       = bus.WriteDest && pend_d;
        in_ready  = !hazard && !waw && (!out_valid || bus.OutReady);
        accept    = bus.InValid && in_ready;
    end

    // Operand muxes: same-cycle write-back beats the bank, immediate beats SrcB.
    always_comb begin
        opnd_a = reg_slice(RegFile, bus.SrcA);
        opnd_b = reg_slice(RegFile, bus.SrcB);
        if (bus.UseSrcA && WbEnable && (WbSelect == bus.SrcA)) opnd_a = WbData;
        if (use_b_reg && WbEnable && (WbSelect == bus.SrcB))   opnd_b = WbData;
        if (bus.UseImm) opnd_b = {{SEXT_W{bus.Imm[IMM_W-1]}}, bus.Imm};
    end

    // Output slot: load on accept, drain on OutReady, otherwise hold.
    always_ff @(posedge Clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_dest  <= '0;
            out_wd    <= 1'b0;
            out_op    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= opnd_a;
            out_b     <= opnd_b;
            out_dest  <= bus.Dest;
            out_wd    <= bus.WriteDest;
            out_op    <= bus.Opcode;
        end else if (bus.OutReady) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.InReady      = in_ready;
    assign bus.OutValid     = out_valid;
    assign bus.OperandA     = out_a;
    assign bus.OperandB     = out_b;
    assign bus.OutDest      = out_dest;
    assign bus.OutWriteDest = out_wd;
    assign bus.OutOpcode    = out_op;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: forwarding, immediates, RAW/WAW stalls, slot, reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled before the next.
// Backpressure: OutReady driven directly by the bench.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic                    Clock = 1'b0;
    logic                    reset;
    logic [REG_N*DATA_W-1:0] RegFile;
    logic                    WbEnable;
    logic [SEL_W-1:0]        WbSelect;
    logic [DATA_W-1:0]       WbData;
    logic [DATA_W-1:0]       reg_bank [REG_N];

    int checks   = 0;
    int failures = 0;

    operand_fetch_if bus ();

    operand_fetch dut (
        .Clock    (Clock),
        .reset    (reset),
        .RegFile  (RegFile),
        .WbEnable (WbEnable),
        .WbSelect (WbSelect),
        .WbData   (WbData),
        .bus      (bus)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        RegFile = '0;
        for (int k = 0; k < REG_N; k++) RegFile[k*DATA_W +: DATA_W] = reg_bank[k];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] sa, input logic ua, input logic [3:0] sb,
                         input logic ub, input logic ui, input logic [7:0] imm,
                         input logic [3:0] dest, input logic wd, input logic [3:0] op);
        bus.InValid   = 1'b1;
        bus.SrcA      = sa;
        bus.UseSrcA   = ua;
        bus.SrcB      = sb;
        bus.UseSrcB   = ub;
        bus.UseImm    = ui;
        bus.Imm       = imm;
        bus.Dest      = dest;
        bus.WriteDest = wd;
        bus.Opcode    = op;
    endtask

    task automatic wb(input logic en, input logic [3:0] sel, input logic [15:0] dat);
        WbEnable = en;
        WbSelect = sel;
        WbData   = dat;
    endtask

    initial begin
        for (int k = 0; k < REG_N; k++) reg_bank[k] = 16'h0;
        reg_bank[2] = 16'h2222;
        reg_bank[3] = 16'h1234;
        reg_bank[5] = 16'h0005;
        reg_bank[7] = 16'h7777;
        reg_bank[9] = 16'h9999;
        wb(1'b0, 4'd0, 16'h0);
        bus.OutReady = 1'b1;

        // Reset with an instruction offered that would set pending[9]
        reset = 1'b1;
        issue(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 4'd9, 1'b1, 4'hE);
        tick();
        tick();
        reset = 1'b0;
        bus.InValid = 1'b0;
        check("rst_out_valid", 32'(bus.OutValid), 32'h0);
        check("rst_operand_a", 32'(bus.OperandA), 32'h0);
        check("rst_operand_b", 32'(bus.OperandB), 32'h0);
        check("rst_out_dest",  32'(bus.OutDest), 32'h0);
        check("rst_out_wd",    32'(bus.OutWriteDest), 32'h0);
        check("rst_out_op",    32'(bus.OutOpcode), 32'h0);
        tick();

        // Register read on both sources; R9 must not be pending after reset
        issue(4'd3, 1'b1, 4'd9, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 4'h1);
        #1 check("rd_in_ready", 32'(bus.InReady), 32'h1);
        tick();
        check("rd_out_valid", 32'(bus.OutValid), 32'h1);
        check("rd_operand_a", 32'(bus.OperandA), 32'h1234);
        check("rd_operand_b", 32'(bus.OperandB), 32'h9999);
        check("rd_out_op",    32'(bus.OutOpcode), 32'h1);
        issue(4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 4'h1);
        tick();
        check("rd_same_b", 32'(bus.OperandB), 32'h1234);

        // Immediates: negative and positive sign extension, back to back
        issue(4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 8'hF0, 4'd0, 1'b0, 4'h2);
        tick();
        check("imm_neg",       32'(bus.OperandB), 32'hFFF0);
        check("imm_neg_op",    32'(bus.OutOpcode), 32'h2);
        issue(4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 8'h7F, 4'd0, 1'b0, 4'h3);
        tick();
        check("imm_pos",       32'(bus.OperandB), 32'h007F);
        check("imm_pos_valid", 32'(bus.OutValid), 32'h1);

        // RAW: writer of R5, then reader stalls until write-back of R5
        issue(4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 4'd5, 1'b1, 4'h3);
        tick();
        check("raw_out_dest", 32'(bus.OutDest), 32'h5);
        check("raw_out_wd",   32'(bus.OutWriteDest), 32'h1);
        issue(4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'h4);
        #1 check("raw_stall0", 32'(bus.InReady), 32'h0);
        tick();
        check("raw_drained", 32'(bus.OutValid), 32'h0);
        check("raw_stall1", 32'(bus.InReady), 32'h0);
        tick();
        wb(1'b1, 4'd5, 16'hBEEF);
        #1 check("raw_wb_ready", 32'(bus.InReady), 32'h1);
        tick();
        reg_bank[5] = 16'hBEEF;
        wb(1'b0, 4'd0, 16'h0);
        check("raw_fwd_a",  32'(bus.OperandA), 32'hBEEF);
        check("raw_fwd_op", 32'(bus.OutOpcode), 32'h4);
        issue(4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'h5);
        #1 check("raw_cleared", 32'(bus.InReady), 32'h1);
        tick();
        check("raw_bank_a", 32'(bus.OperandA), 32'hBEEF);

        // Backpressure: hold slot for 3 cycles, then replace in the draining cycle
        bus.InValid = 1'b0;
        tick();
        bus.OutReady = 1'b0;
        issue(4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 8'h11, 4'd0, 1'b0, 4'h5);
        tick();
        issue(4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 8'h22, 4'd0, 1'b0, 4'h6);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", 32'(bus.InReady), 32'h0);
            tick();
            check("bp_valid", 32'(bus.OutValid), 32'h1);
            check("bp_hold_a", 32'(bus.OperandA), 32'h1234);
            check("bp_hold_b", 32'(bus.OperandB), 32'h0011);
            check("bp_hold_op", 32'(bus.OutOpcode), 32'h5);
        end
        bus.OutReady = 1'b1;
        #1 check("bp_release_ready", 32'(bus.InReady), 32'h1);
        tick();
        check("bp_replace_valid", 32'(bus.OutValid), 32'h1);
        check("bp_replace_op", 32'(bus.OutOpcode), 32'h6);
        check("bp_replace_a", 32'(bus.OperandA), 32'h2222);
        check("bp_replace_b", 32'(bus.OperandB), 32'h0022);

        // WAW on R2, then set-wins when re-issue coincides with write-back
        issue(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 4'd2, 1'b1, 4'h7);
        tick();
        issue(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 4'd2, 1'b1, 4'h8);
        #1 check("waw_stall0", 32'(bus.InReady), 32'h0);
        tick();
        check("waw_stall1", 32'(bus.InReady), 32'h0);
        wb(1'b1, 4'd2, 16'h3333);
        #1 check("waw_wb_ready", 32'(bus.InReady), 32'h1);
        tick();
        reg_bank[2] = 16'h3333;
        wb(1'b0, 4'd0, 16'h0);
        check("waw_out_op", 32'(bus.OutOpcode), 32'h8);
        issue(4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'h9);
        #1 check("waw_set_wins", 32'(bus.InReady), 32'h0);
        tick();
        wb(1'b1, 4'd2, 16'h4444);
        #1 check("waw_wb2_ready", 32'(bus.InReady), 32'h1);
        tick();
        reg_bank[2] = 16'h4444;
        wb(1'b0, 4'd0, 16'h0);
        check("waw_fwd_a", 32'(bus.OperandA), 32'h4444);

        // Reset during a stall on pending R7
        issue(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 4'd7, 1'b1, 4'hA);
        tick();
        issue(4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'hB);
        #1 check("rst_stall", 32'(bus.InReady), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_out_valid", 32'(bus.OutValid), 32'h0);
        check("rst2_in_ready", 32'(bus.InReady), 32'h1);
        tick();
        check("rst2_accept_valid", 32'(bus.OutValid), 32'h1);
        check("rst2_accept_a", 32'(bus.OperandA), 32'h7777);
        check("rst2_accept_op", 32'(bus.OutOpcode), 32'hB);
        bus.InValid = 1'b0;
        tick();
        check("final_drain", 32'(bus.OutValid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Pipeline stage directly downstream of the 16 x 16-bit register bank. Takes a decoded instruction and picks its two source operands from the bank's flattened outputs. Forwards same-cycle writeback data and tracks in-flight destination writes in a pending scoreboard, stalling on hazards. Registers the result into one valid/ready output slot for the execute stage.

## Interface
- DATA_W, 16, operand and register width
- REG_N, 16, register count; select fields are log2(REG_N) = 4 bits
- Clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- RegFile  in  256  bank outputs; register k at bits [16k+15:16k]
- InValid  in  1  instruction offered
- InReady  out  1  instruction accepted this cycle when high with InValid
- SrcA, SrcB  in  4 each  source register selects
- UseSrcA, UseSrcB  in  1 each  source actually read; unused sources never cause a stall
- UseImm  in  1  OperandB comes from Imm, not SrcB
- Imm  in  8  immediate, sign-extended to 16
- Dest  in  4  destination register
- WriteDest  in  1  instruction will write Dest
- Opcode  in  4  passed through
- WbEnable  in  1  write-back to the bank this cycle; same signal that drives the bank
- WbSelect  in  4  write-back register
- WbData  in  16  write-back data; same value as the bank's InputBus
- OutValid  out  1  output slot full
- OutReady  in  1  execute consumes the slot
- OperandA, OperandB  out  16 each
- OutDest  out  4
- OutWriteDest  out  1
- OutOpcode  out  4

## Operation
- Scoreboard: 16 pending bits, one per register.
- A hazard exists if either of these holds:
  - (UseSrcA and pending[SrcA]) and not (WbEnable and WbSelect==SrcA)
  - the same test on B when UseSrcB and not UseImm
- WAW stall: WriteDest and pending[Dest] and not (WbEnable and WbSelect==Dest).
- InReady = not hazard and not WAW and (not OutValid or OutReady). InReady is combinational and does not depend on InValid.
- Accept = InValid and InReady.
- Forwarding: if WbEnable and WbSelect equals a used source, that operand takes WbData. Otherwise it takes RegFile. This covers the bank writing at the same edge.
- OperandB = {{8{Imm[7]}}, Imm} when UseImm.
- On accept with WriteDest: pending[Dest] is set.
- On WbEnable: pending[WbSelect] is cleared.
- Set and clear of the same register in the same cycle: set wins.
- Write-back to a non-pending register only clears the bit (no error).
- Output slot:
  - Loads on accept.
  - Clears OutValid on OutReady with no accept.
  - Holds all payload stable while OutValid and not OutReady.
- Reset clears the slot and the whole scoreboard, including mid-stall. The instruction presented during the reset cycle is not accepted.

## Timing
- Reset values: OutValid=0; OperandA, OperandB, OutDest, OutOpcode = 0; OutWriteDest=0; pending = 0.
- Latency: accept at edge N gives OutValid=1 with payload after edge N.
- Throughput: one per cycle when OutReady is held high and there are no hazards.
- Back-to-back dependent instructions: the consumer stalls until the cycle WbEnable/WbSelect matches. It is accepted in that cycle with WbData forwarded, so the stall costs 0 extra cycles after write-back.
- Simultaneous accept and OutReady: the slot is replaced and OutValid stays 1.
- InValid low: nothing happens; pending is unchanged except by write-back.

## Structure
- Shared package:
  - DATA_W, REG_N, and the select width.
  - The opcode typedef (4-bit).
  - The sign-extension width constant.
  - The RegFile slicing helper for extracting register k.
- Sub-module operand_scoreboard:
  - Holds the 16 pending bits with set/clear ports.
  - Exposes combinational pending lookups for SrcA, SrcB and Dest, including the write-back bypass.
- Top level holds the forwarding muxes, immediate extension, handshake and output slot.

## Test plan
- After reset, R3=0x1234 in RegFile; issue SrcA=3, SrcB=3, UseImm=0, OutReady=1 → next cycle OutValid=1, OperandA=OperandB=0x1234.
- UseImm=1, Imm=0xF0 → OperandB=0xFFF0; Imm=0x7F → OperandB=0x007F.
- Issue Dest=5, WriteDest=1, then SrcA=5 → InReady=0 until WbEnable with WbSelect=5, WbData=0xBEEF; accepted that cycle, OperandA=0xBEEF, pending[5] cleared.
- OutReady=0 for 3 cycles after an accept → payload stable, InReady=0. Then OutReady=1 with a new InValid → slot replaced in the same cycle.
- WAW: Dest=2 pending, new Dest=2 → stalls until write-back. In the same cycle as write-back, a new accept sets pending[2] again (set wins).
- Assert reset while a stall is in progress and pending[7]=1 → after reset OutValid=0 and pending all 0; SrcA=7 is then accepted immediately.
